down_counter: RTL and testbench
===============================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 The block SHALL have parameter Size, default 5, which sets the count and load width in bits.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset sampled on the rising edge of clock.
REQ-004 The block SHALL have port load_valid, input, 1 bit: request to load a new start value.
REQ-005 The block SHALL have port load_value, input, Size bits: start value, captured when load_valid and load_ready are both 1.
REQ-006 The block SHALL have port load_ready, output, 1 bit: high when a load is accepted.
REQ-007 The block SHALL have port enable, input, 1 bit: decrement qualifier.
REQ-008 The block SHALL have port auto_reload, input, 1 bit: restart from the captured start value on terminal count.
REQ-009 The block SHALL have port cancel, input, 1 bit: abort a run in progress.
REQ-010 The block SHALL have port count, output, Size bits: current count value, driven from a register.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-012 The block SHALL have port expired, output, 1 bit: registered single-cycle terminal-count pulse.

Function
REQ-013 The block SHALL implement a two-state FSM with states IDLE and RUN.
REQ-014 In IDLE, load_ready SHALL be 1 and busy SHALL be 0; in RUN, load_ready SHALL be 0 and busy SHALL be 1.
REQ-015 On the IDLE handshake, count and the internal reload_reg SHALL both take load_value at that edge.
REQ-016 If the IDLE handshake has a nonzero load_value, the next state SHALL be RUN.
REQ-017 If the IDLE handshake has load_value == 0, expired SHALL be 1 for the next cycle and the state SHALL remain IDLE.
REQ-018 In RUN with enable=1 and count>1, count SHALL decrement by 1 per edge; with enable=0, count SHALL hold.
REQ-019 In RUN with enable=1 and count==1 (terminal edge), expired SHALL be 1 for exactly the following cycle.
REQ-020 At the terminal edge, if auto_reload=1, count SHALL take reload_reg and the state SHALL remain RUN.
REQ-021 At the terminal edge, if auto_reload=0, count SHALL become 0 and the next state SHALL be IDLE.
REQ-022 count SHALL never wrap below 0 and never exceed 2^Size-1; decrement SHALL be modulo-free, Size-bit unsigned.
REQ-023 In RUN, load_valid SHALL be ignored and no capture SHALL occur.
REQ-024 In RUN, cancel=1 SHALL force count to 0 and the next state to IDLE with no expired pulse.
REQ-025 cancel SHALL take priority over decrement, terminal count and auto_reload when they coincide.
REQ-026 cancel in IDLE SHALL have no effect.
REQ-027 expired SHALL be 0 in every cycle other than those defined in REQ-017 and REQ-019.
REQ-028 auto_reload SHALL be sampled only at the terminal edge; changes mid-run SHALL take effect at the next terminal edge.

Reset
REQ-029 When reset=0 at a rising edge, the next state SHALL be IDLE with count=0, reload_reg=0, expired=0, busy=0 and load_ready=1.
REQ-030 Reset SHALL override every other input, including a simultaneous load, cancel or terminal count.
REQ-031 Reset asserted mid-run SHALL abort the run with no expired pulse.

Structure
REQ-032 A shared package down_counter_pkg SHALL hold the FSM state enumeration (IDLE, RUN) and the default Size constant.
REQ-033 The block SHALL be a single module with no sub-modules; the FSM and datapath registers SHALL reside in one always block per register group.

Verification
REQ-034 With Size=5 and auto_reload=0, loading 3 with enable held high SHALL give count 3,2,1,0 on successive cycles, expired=1 in the cycle count=0, and load_ready=1 from that cycle.
REQ-035 Loading 31 with auto_reload=1 and enable high SHALL produce an expired pulse every 31 cycles, with count=31 in each pulse cycle.
REQ-036 Loading 4 with enable pattern 1,0,0,1,1,1 SHALL give count 4,3,3,3,2,1,0.
REQ-037 Loading 0 SHALL give expired=1 on the next cycle, busy=0 throughout and count=0.
REQ-038 Asserting cancel at count=10 SHALL give count=0, IDLE and expired=0 on the next cycle; cancel coinciding with the terminal edge SHALL also give expired=0.
REQ-039 Driving reset=0 for one edge at count=7 during RUN SHALL give all REQ-029 reset values on the next cycle; a load issued the cycle after reset releases SHALL be accepted.

Source files
------------

// File: rtl/down_counter_pkg.sv
// Shared definitions for the loadable down counter: FSM states and default width.
package down_counter_pkg;

  localparam int unsigned DEFAULT_SIZE = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with handshake load, optional auto-reload on terminal
// count, cancel, and a registered single-cycle expiry pulse.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int unsigned Size = DEFAULT_SIZE
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_valid,
  input  logic [Size-1:0] load_value,
  output logic            load_ready,
  input  logic            enable,
  input  logic            auto_reload,
  input  logic            cancel,
  output logic [Size-1:0] count,
  output logic            busy,
  output logic            expired
);

  localparam logic [Size-1:0] COUNT_ONE = Size'(1);

  state_t          r_state;
  logic [Size-1:0] r_count;
  logic [Size-1:0] r_reload;
  logic            r_expired;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (load_valid) begin
            r_count  <= load_value;
            r_reload <= load_value;
            // A zero start value expires immediately without entering RUN.
            if (load_value == '0) r_expired <= 1'b1;
            else                  r_state   <= RUN;
          end
        end
        RUN: begin
          if (cancel) begin
            r_count <= '0;
            r_state <= IDLE;
          end else if (enable) begin
            if (r_count > COUNT_ONE) begin
              r_count <= r_count - COUNT_ONE;
            end else begin
              r_expired <= 1'b1;
              if (auto_reload) begin
                r_count <= r_reload;
              end else begin
                r_count <= '0;
                r_state <= IDLE;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign load_ready = (r_state == IDLE);
  assign busy       = (r_state == RUN);
  assign count      = r_count;
  assign expired    = r_expired;

endmodule

// File: tb/tb_down_counter.sv
// Directed and randomized checks of down_counter against a behavioural model.
module tb_down_counter;

  localparam int SZ = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          load_valid;
  logic [SZ-1:0] load_value;
  logic          load_ready;
  logic          enable;
  logic          auto_reload;
  logic          cancel;
  logic [SZ-1:0] count;
  logic          busy;
  logic          expired;

  int checks = 0;
  int errors = 0;

  // Model: value left on the counter, start value, whether a run is active,
  // and whether the previous edge produced a terminal/zero-load event.
  int mcount  = 0;
  int mstart  = 0;
  bit mactive = 0;
  bit mpulse  = 0;

  down_counter #(.Size(SZ)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .enable     (enable),
    .auto_reload(auto_reload),
    .cancel     (cancel),
    .count      (count),
    .busy       (busy),
    .expired    (expired)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_edge();
    bit fire;
    fire = 0;
    if (reset === 1'b0) begin
      mactive = 0; mcount = 0; mstart = 0;
    end else if (!mactive) begin
      if (load_valid) begin
        mstart = int'(load_value);
        mcount = mstart;
        if (mstart == 0) fire = 1;
        else             mactive = 1;
      end
    end else if (cancel) begin
      mactive = 0; mcount = 0;
    end else if (enable) begin
      if (mcount >= 2) begin
        mcount = mcount - 1;
      end else begin
        fire = 1;
        if (auto_reload) mcount = mstart;
        else begin mcount = 0; mactive = 0; end
      end
    end
    mpulse = fire;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clock);
    #1;
    chk("count",      32'(count),      mcount);
    chk("busy",       32'(busy),       int'(mactive));
    chk("load_ready", 32'(load_ready), int'(!mactive));
    chk("expired",    32'(expired),    int'(mpulse));
  endtask

  task automatic do_load(input int v);
    load_valid = 1'b1;
    load_value = SZ'(v);
    cycle();
    load_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; load_valid = 1'b0; load_value = '0;
    enable = 1'b0; auto_reload = 1'b0; cancel = 1'b0;

    // Reset state
    cycle(); cycle();
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(load_ready), 1);
    reset = 1'b1;
    cycle();

    // Load 3, enable high, no reload: 3,2,1,0 with pulse at 0
    enable = 1'b1;
    do_load(3);
    chk("l3_c0", 32'(count), 3);
    cycle(); chk("l3_c1", 32'(count), 2);
    cycle(); chk("l3_c2", 32'(count), 1);
    cycle(); chk("l3_c3", 32'(count), 0);
    chk("l3_exp", 32'(expired), 1);
    chk("l3_ready", 32'(load_ready), 1);
    cycle(); chk("l3_exp_done", 32'(expired), 0);

    // Load 4 with enable pattern 1,0,0,1,1,1
    do_load(4);
    chk("l4_c0", 32'(count), 4);
    enable = 1'b1; cycle(); chk("l4_c1", 32'(count), 3);
    enable = 1'b0; cycle(); chk("l4_c2", 32'(count), 3);
    cycle();                chk("l4_c3", 32'(count), 3);
    enable = 1'b1; cycle(); chk("l4_c4", 32'(count), 2);
    cycle();                chk("l4_c5", 32'(count), 1);
    cycle();                chk("l4_c6", 32'(count), 0);
    chk("l4_exp", 32'(expired), 1);

    // Load 0: immediate pulse, never busy
    do_load(0);
    chk("l0_exp", 32'(expired), 1);
    chk("l0_busy", 32'(busy), 0);
    cycle();
    chk("l0_exp_done", 32'(expired), 0);
    chk("l0_count", 32'(count), 0);

    // Load 31 with auto-reload: pulse every 31 cycles at count 31
    auto_reload = 1'b1;
    do_load(31);
    for (int k = 1; k <= 62; k++) begin
      cycle();
      if (k % 31 == 0) begin
        chk("ar_exp", 32'(expired), 1);
        chk("ar_count", 32'(count), 31);
      end
    end
    chk("ar_busy", 32'(busy), 1);
    cancel = 1'b1; cycle(); cancel = 1'b0;
    auto_reload = 1'b0;

    // Cancel at count 10
    do_load(20);
    for (int k = 0; k < 10; k++) cycle();
    chk("cn_pre", 32'(count), 10);
    cancel = 1'b1; cycle(); cancel = 1'b0;
    chk("cn_count", 32'(count), 0);
    chk("cn_idle", 32'(busy), 0);
    chk("cn_exp", 32'(expired), 0);

    // Cancel on the terminal edge suppresses the pulse
    do_load(2);
    cycle(); chk("ct_pre", 32'(count), 1);
    cancel = 1'b1; auto_reload = 1'b1; cycle(); cancel = 1'b0; auto_reload = 1'b0;
    chk("ct_exp", 32'(expired), 0);
    chk("ct_count", 32'(count), 0);

    // Cancel in IDLE has no effect on a load
    cancel = 1'b1; do_load(6); cancel = 1'b0;
    chk("ci_count", 32'(count), 6);
    chk("ci_busy", 32'(busy), 1);
    cancel = 1'b1; cycle(); cancel = 1'b0;

    // Reset mid-run at count 7, with a load pending; then load after release
    do_load(15);
    for (int k = 0; k < 8; k++) cycle();
    chk("rr_pre", 32'(count), 7);
    reset = 1'b0; load_valid = 1'b1; load_value = 5'd12;
    cycle();
    load_valid = 1'b0; reset = 1'b1;
    chk("rr_count", 32'(count), 0);
    chk("rr_busy", 32'(busy), 0);
    chk("rr_ready", 32'(load_ready), 1);
    chk("rr_exp", 32'(expired), 0);
    do_load(9);
    chk("rr_load", 32'(count), 9);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      reset       = ($urandom_range(0, 63) != 0);
      load_valid  = ($urandom_range(0, 3) == 0);
      load_value  = ($urandom_range(0, 2) == 0) ? SZ'($urandom_range(0, 3))
                                                : SZ'($urandom_range(0, 31));
      enable      = ($urandom_range(0, 3) != 0);
      auto_reload = $urandom_range(0, 1) != 0;
      cancel      = ($urandom_range(0, 23) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
